// File: rtl/mux_scan_reg.sv
// Registered N-channel multiplexer with manual select and auto-scan modes.
// The output data, channel tag and change strobe are registered together, so they stay aligned.
module mux_scan_reg #(
   parameter  int WIDTH = 2,
   parameter  int NCH   = 4,
   parameter  int DWELL = 4,
   localparam int SELW  = $clog2(NCH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCH*WIDTH-1:0]  din,
   input  logic                  mode,
   input  logic [SELW-1:0]       sel,
   input  logic                  hold,
   output logic [WIDTH-1:0]      y,
   output logic [SELW-1:0]       ch,
   output logic                  strobe,
   output logic                  err
);

   localparam int              CNTW     = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [SELW-1:0] LAST_CH  = SELW'(NCH - 1);
   localparam logic [CNTW-1:0] LAST_CNT = CNTW'(DWELL - 1);
   localparam logic [SELW:0]   NCH_EXT  = (SELW + 1)'(NCH);

   typedef enum logic [1:0] {
      ST_RESET,
      ST_HELD,
      ST_MANUAL,
      ST_AUTO
   } state_e;

   state_e           w_state;

   logic [SELW-1:0]  r_cur,  w_cur_nxt;
   logic [CNTW-1:0]  r_cnt,  w_cnt_nxt;
   logic             r_prev_mode, w_prev_mode_nxt;
   logic [WIDTH-1:0] r_y,    w_y_nxt;
   logic [SELW-1:0]  r_ch,   w_ch_nxt;
   logic             r_strobe, w_strobe_nxt;
   logic             r_err,  w_err_nxt;
   logic [WIDTH-1:0] w_cur_data;

   // No extra transition cycles: the state follows rst/hold/mode directly each edge.
   assign w_state = rst  ? ST_RESET  :
                    hold ? ST_HELD   :
                    mode ? ST_AUTO   : ST_MANUAL;

   // r_cur is always below NCH, so the slice never leaves the bus.
   assign w_cur_data = din[r_cur*WIDTH +: WIDTH];

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      w_cur_nxt       = r_cur;
      w_cnt_nxt       = r_cnt;
      w_prev_mode_nxt = r_prev_mode;
      w_y_nxt         = r_y;
      w_ch_nxt        = r_ch;
      w_strobe_nxt    = 1'b0;
      w_err_nxt       = 1'b0;

      if (w_state == ST_MANUAL || w_state == ST_AUTO) begin
         w_y_nxt      = w_cur_data;
         w_ch_nxt     = r_cur;
         w_strobe_nxt = (r_cur != r_ch);
      end

      case (w_state)
         ST_MANUAL: begin
            w_cnt_nxt       = '0;
            w_prev_mode_nxt = 1'b0;
            if ({1'b0, sel} < NCH_EXT) w_cur_nxt = sel;
            else                       w_err_nxt = 1'b1;
         end
         ST_AUTO: begin
            w_prev_mode_nxt = 1'b1;
            if (!r_prev_mode) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == LAST_CNT) begin
               w_cnt_nxt = '0;
               w_cur_nxt = (r_cur == LAST_CH) ? '0 : r_cur + SELW'(1);
            end else begin
               w_cnt_nxt = r_cnt + CNTW'(1);
            end
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cur       <= '0;
         r_cnt       <= '0;
         r_prev_mode <= 1'b0;
         r_y         <= '0;
         r_ch        <= '0;
         r_strobe    <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_cur       <= w_cur_nxt;
         r_cnt       <= w_cnt_nxt;
         r_prev_mode <= w_prev_mode_nxt;
         r_y         <= w_y_nxt;
         r_ch        <= w_ch_nxt;
         r_strobe    <= w_strobe_nxt;
         r_err       <= w_err_nxt;
      end
   end

   assign y      = r_y;
   assign ch     = r_ch;
   assign strobe = r_strobe;
   assign err    = r_err;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Bench for mux_scan_reg: a 4-channel DWELL=4 instance and a 3-channel DWELL=1 instance share stimulus.
// A behavioural model is compared every cycle, and directed literal checks pin the model.
module tb_mux_scan_reg;

   logic       clk;
   logic       rst;
   logic [7:0] din;
   logic       mode;
   logic [1:0] sel;
   logic       hold;

   logic [1:0] y4, ch4, y3, ch3;
   logic       str4, err4, str3, err3;

   int  n_checks = 0;
   int  n_errors = 0;
   bit  chk_en   = 0;

   logic [1:0] tbl [4] = '{2'b00, 2'b10, 2'b01, 2'b11};

   mux_scan_reg #(.WIDTH(2), .NCH(4), .DWELL(4)) u_dut4 (
      .clk(clk), .rst(rst), .din(din), .mode(mode), .sel(sel), .hold(hold),
      .y(y4), .ch(ch4), .strobe(str4), .err(err4)
   );

   mux_scan_reg #(.WIDTH(2), .NCH(3), .DWELL(1)) u_dut3 (
      .clk(clk), .rst(rst), .din(din[5:0]), .mode(mode), .sel(sel), .hold(hold),
      .y(y3), .ch(ch3), .strobe(str3), .err(err3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a channel pointer plus a "cycles left in this dwell" countdown, and
   // outputs that show the pointer as it stood before each edge.
   int  nch_a   [2] = '{4, 3};
   int  dwell_a [2] = '{4, 1};
   int  m_cur   [2];
   int  m_left  [2];
   bit  m_auto  [2];
   int  e_y     [2];
   int  e_ch    [2];
   bit  e_str   [2];
   bit  e_err   [2];

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_cur[d] = 0; m_left[d] = 0; m_auto[d] = 0;
            e_y[d] = 0; e_ch[d] = 0; e_str[d] = 0; e_err[d] = 0;
         end else if (hold) begin
            e_str[d] = 0; e_err[d] = 0;
         end else begin
            e_y[d]   = int'((din >> (m_cur[d] * 2)) & 8'h3);
            e_str[d] = (m_cur[d] != e_ch[d]);
            e_ch[d]  = m_cur[d];
            e_err[d] = 0;
            if (!mode) begin
               m_auto[d] = 0;
               if (int'(sel) < nch_a[d]) m_cur[d] = int'(sel);
               else                      e_err[d] = 1;
            end else if (!m_auto[d]) begin
               m_auto[d] = 1;
               m_left[d] = dwell_a[d];
            end else if (m_left[d] == 1) begin
               m_cur[d]  = (m_cur[d] + 1) % nch_a[d];
               m_left[d] = dwell_a[d];
            end else begin
               m_left[d] = m_left[d] - 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m4_y",   y4,   e_y[0]);
         check("m4_ch",  ch4,  e_ch[0]);
         check("m4_str", str4, e_str[0]);
         check("m4_err", err4, e_err[0]);
         check("m3_y",   y3,   e_y[1]);
         check("m3_ch",  ch3,  e_ch[1]);
         check("m3_str", str3, e_str[1]);
         check("m3_err", err3, e_err[1]);
      end
   end

   initial begin
      int exp_ch;
      rst = 1'b1; mode = 1'b0; sel = 2'd0; hold = 1'b0;
      din = 8'b11_01_10_00;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("rst_y",   y4,   0);
      check("rst_ch",  ch4,  0);
      check("rst_str", str4, 0);
      check("rst_err", err4, 0);
      rst = 1'b0;

      // Manual select: two-edge latency and one strobe per change.
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         @(negedge clk);
         if (s > 0) check("man_lat1_ch", ch4, s - 1);
         @(negedge clk);
         check("man_ch",  ch4,  s);
         check("man_y",   y4,   tbl[s]);
         check("man_str", str4, (s != 0));
         if (s == 3) begin
            check("inv3_err", err3, 1);
            check("inv3_ch",  ch3,  2);
            check("inv3_y",   y3,   2'b01);
         end
         repeat (8) @(negedge clk);
      end

      // Auto scan from channel 0.
      sel = 2'd0;
      repeat (3) @(negedge clk);
      mode = 1'b1;
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         exp_ch = (i < 5) ? 0 : ((i - 5) / 4 + 1) % 4;
         check("auto_ch",  ch4,  exp_ch);
         check("auto_y",   y4,   tbl[exp_ch]);
         check("auto_str", str4, (i >= 5 && (i - 5) % 4 == 0));
         check("auto3_range", (ch3 < 2'd3), 1);
      end

      // Hold mid-dwell on channel 2, with din channel 2 changing underneath.
      repeat (4) @(negedge clk);
      check("pre_hold_ch1", ch4, 1);
      repeat (2) @(negedge clk);
      check("pre_hold_ch2", ch4, 2);
      check("pre_hold_y",   y4,  2'b01);
      hold = 1'b1;
      din[5:4] = 2'b10;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_ch",  ch4,  2);
         check("hold_y",   y4,   2'b01);
         check("hold_str", str4, 0);
      end
      hold = 1'b0;
      @(negedge clk);
      check("rel_y",  y4,  2'b10);
      check("rel_ch", ch4, 2);
      @(negedge clk);
      check("rel_ch_last", ch4, 2);
      @(negedge clk);
      check("rel_ch3",  ch4,  3);
      check("rel_str3", str4, 1);
      din[5:4] = 2'b01;

      // Reset mid-dwell (cnt=2 on channel 1) with auto kept on.
      repeat (9) @(negedge clk);
      check("pre_rst_ch", ch4, 1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_y",   y4,   0);
      check("mid_rst_ch",  ch4,  0);
      check("mid_rst_str", str4, 0);
      check("mid_rst_err", err4, 0);
      rst = 1'b0;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         exp_ch = (i < 5) ? 0 : (i - 5) / 4 + 1;
         check("post_rst_ch",  ch4,  exp_ch);
         check("post_rst_str", str4, (i >= 5 && (i - 5) % 4 == 0));
      end

      // Auto -> manual with sel=2, then back to auto.
      @(negedge clk);
      check("a2m_ch0", ch4, 0);
      sel = 2'd2; mode = 1'b0;
      @(negedge clk);
      check("a2m_lat1_ch",  ch4,  0);
      check("a2m_lat1_str", str4, 0);
      @(negedge clk);
      check("a2m_ch",  ch4,  2);
      check("a2m_str", str4, 1);
      check("a2m_y",   y4,   2'b01);
      @(negedge clk);
      check("a2m_str_off", str4, 0);
      mode = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("m2a_ch",  ch4,  (i < 5) ? 2 : 3);
         check("m2a_str", str4, (i == 5));
      end

      // One-cycle invalid select on the 3-channel instance, then wrap in auto.
      mode = 1'b0; sel = 2'd1;
      repeat (3) @(negedge clk);
      check("n3_ch", ch3, 1);
      check("n3_y",  y3,  2'b10);
      sel = 2'd3;
      @(negedge clk);
      check("n3_err",    err3, 1);
      check("n3_err_ch", ch3,  1);
      check("n3_err_y",  y3,  2'b10);
      check("n4_no_err", err4, 0);
      sel = 2'd1;
      @(negedge clk);
      check("n3_err_off", err3, 0);
      check("n3_ch_keep", ch3,  1);
      mode = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("n3_wrap_ch", ch3, (i < 2) ? 1 : i % 3);
      end

      // Reset wins over hold.
      hold = 1'b1; rst = 1'b1;
      @(negedge clk);
      check("rst_hold_ch4", ch4, 0);
      check("rst_hold_y4",  y4,  0);
      check("rst_hold_ch3", ch3, 0);
      rst = 1'b0; hold = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
